// File: rtl/ac_requant.sv
// ac_requant -- output requantization stage behind the accumulator.
//
// Each accepted accumulated sum is biased, rounded and arithmetically shifted
// right. It is then optionally clamped at zero (ReLU) and saturated to
// OUT_WIDTH. The result is queued in a small in-order FIFO that feeds a
// valid/ready consumer port.
//
// Upstream flow control is credit based. acc_ready only admits a sum when the
// FIFO is guaranteed to have room for it once it leaves the pipeline. Because
// of that the pipeline never stalls and an accepted sum is never dropped.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   acc_data   signed accumulated sum            (ACC_WIDTH)
//   acc_valid  acc_data is a final sum this cycle
//   acc_ready  a sum may be accepted this cycle (register-derived only)
//   bias       signed bias, sampled with acc_data (ACC_WIDTH)
//   shift      right-shift amount, stable while sums are in flight
//   relu_en    clamp negative results to zero, stable while in flight
//   out_data   FIFO head, signed; zero when out_valid is low (OUT_WIDTH)
//   out_valid  FIFO is non-empty
//   out_ready  consumer takes the head this cycle
//   sat_clr    synchronous clear of sat_cnt (wins over an increment)
//   sat_cnt    number of saturated results, sticks at 0xFFFF

module ac_requant #(
  parameter int ACC_WIDTH   = 35,
  parameter int OUT_WIDTH   = 16,
  parameter int SHIFT_WIDTH = 5,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ACC_WIDTH-1:0]   acc_data,
  input  logic                   acc_valid,
  output logic                   acc_ready,
  input  logic [ACC_WIDTH-1:0]   bias,
  input  logic [SHIFT_WIDTH-1:0] shift,
  input  logic                   relu_en,
  output logic [OUT_WIDTH-1:0]   out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   sat_clr,
  output logic [15:0]            sat_cnt
);

  // Two guard bits: the bias addition and the rounding constant cannot
  // overflow at this width.
  localparam int SUM_W = ACC_WIDTH + 2;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  // Occupancy plus in-flight count can exceed FIFO_DEPTH, so keep headroom.
  localparam int CNT_W = PTR_W + 2;

  localparam logic signed [SUM_W-1:0] L_MAX =
    {{(SUM_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] L_MIN = ~L_MAX;

  // Control state
  logic                    r_rst_q;
  logic                    r_s1_vld;
  logic                    r_s2_vld;
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [CNT_W-1:0]        r_count;
  logic [15:0]             r_sat_cnt;

  // Datapath state
  logic signed [SUM_W-1:0] r_s1_sum;
  logic signed [SUM_W-1:0] r_s2_val;
  logic [OUT_WIDTH-1:0]    r_mem [FIFO_DEPTH];

  // Combinational signals
  logic                    w_accept;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_sat_hi;
  logic                    w_sat_lo;
  logic [CNT_W-1:0]        w_inflight;
  logic signed [SUM_W-1:0] w_acc_ext;
  logic signed [SUM_W-1:0] w_bias_ext;
  logic signed [SUM_W-1:0] w_sum_in;
  logic signed [SUM_W-1:0] w_round;
  logic signed [SUM_W-1:0] w_shifted;
  logic signed [SUM_W-1:0] w_relu;
  logic [OUT_WIDTH-1:0]    w_sat_out;

  // ---------------------------------------------------------------------------
  // Credit and handshakes
  // ---------------------------------------------------------------------------
  // S3 is the combinational saturation in front of the FIFO write port. It
  // holds no register of its own, so only the S1 and S2 valid bits are in
  // flight.
  assign w_inflight = CNT_W'(r_s1_vld) + CNT_W'(r_s2_vld);
  assign acc_ready  = !r_rst_q && ((r_count + w_inflight) < CNT_W'(FIFO_DEPTH));
  assign w_accept   = acc_valid & acc_ready;
  assign out_valid  = (r_count != '0);
  assign w_push     = r_s2_vld;
  assign w_pop      = out_valid & out_ready;

  // ---------------------------------------------------------------------------
  // S1 input: sign-extend and add the bias
  // ---------------------------------------------------------------------------
  assign w_acc_ext  = {{2{acc_data[ACC_WIDTH-1]}}, acc_data};
  assign w_bias_ext = {{2{bias[ACC_WIDTH-1]}}, bias};
  assign w_sum_in   = w_acc_ext + w_bias_ext;

  // ---------------------------------------------------------------------------
  // S2 input: round half up, arithmetic shift, then ReLU
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable assigned in a combinational block gets a default
    // first. Otherwise a path that skips the assignment infers a latch.
    w_round = '0;
    if (shift != '0) begin
      w_round = SUM_W'(1) << (shift - SHIFT_WIDTH'(1));
    end
    w_shifted = (r_s1_sum + w_round) >>> shift;
    w_relu    = (relu_en && w_shifted[SUM_W-1]) ? '0 : w_shifted;
  end

  // ---------------------------------------------------------------------------
  // S3: saturate the S2 value on its way into the FIFO
  // ---------------------------------------------------------------------------
  assign w_sat_hi = (r_s2_val > L_MAX);
  assign w_sat_lo = (r_s2_val < L_MIN);

  always_comb begin
    w_sat_out = r_s2_val[OUT_WIDTH-1:0];
    if (w_sat_hi) begin
      w_sat_out = L_MAX[OUT_WIDTH-1:0];
    end else if (w_sat_lo) begin
      w_sat_out = L_MIN[OUT_WIDTH-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers (reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments. Every register
    // then samples pre-edge values, no matter what order the statements are in.
    r_rst_q <= rst;
    if (rst) begin
      r_s1_vld  <= 1'b0;
      r_s2_vld  <= 1'b0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_sat_cnt <= '0;
    end else begin
      r_s1_vld <= w_accept;
      r_s2_vld <= r_s1_vld;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      if (sat_clr) begin
        r_sat_cnt <= '0;
      end else if (w_push && (w_sat_hi || w_sat_lo) && (r_sat_cnt != 16'hFFFF)) begin
        r_sat_cnt <= r_sat_cnt + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers and FIFO storage (no reset)
  // ---------------------------------------------------------------------------
  // NOTE: data registers and the FIFO array are not reset. The valid bits and
  // the occupancy count decide what is meaningful, and leaving the storage
  // unreset lets it map onto plain flops or RAM.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_s1_sum <= w_sum_in;
    end
    r_s2_val <= w_relu;
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_sat_out;
    end
  end

  // The head comes straight from the storage register. It is masked so that
  // nothing stale shows while the FIFO is empty.
  assign out_data = out_valid ? r_mem[r_rd_ptr] : '0;
  assign sat_cnt  = r_sat_cnt;

endmodule

// File: doc/ac_requant.md
# ac_requant

Output post-processing stage placed directly downstream of the accumulator (AC). It captures each final accumulated partial sum (`ACC_WIDTH`, signed), then applies bias addition, a rounding arithmetic right shift, optional ReLU and signed saturation to `OUT_WIDTH`. Results are buffered in a small FIFO behind a valid/ready output port. Upstream flow control is credit-based, so the internal pipeline never stalls and never drops an accepted sum.

## Interface
- `ACC_WIDTH`, 35: width of the incoming accumulated sum and of the bias, both signed two's complement.
- `OUT_WIDTH`, 16: width of the quantized output, signed.
- `SHIFT_WIDTH`, 5: width of the shift amount; shift range is 0..2^SHIFT_WIDTH-1.
- `FIFO_DEPTH`, 4: number of output FIFO entries; must be a power of 2 and ≥ 2.
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `acc_data`  in  ACC_WIDTH  final accumulated sum from AC `data_out`, signed.
- `acc_valid`  in  1  `acc_data` is a final sum to be quantized this cycle.
- `acc_ready`  out  1  block can accept a sum this cycle; the sum is accepted when `acc_valid & acc_ready`.
- `bias`  in  ACC_WIDTH  signed bias; sampled together with `acc_data`.
- `shift`  in  SHIFT_WIDTH  right-shift amount; held stable while any sum is in flight.
- `relu_en`  in  1  clamp negative results to 0; held stable while any sum is in flight.
- `out_data`  out  OUT_WIDTH  FIFO head, signed; reads as 0 whenever `out_valid` is 0.
- `out_valid`  out  1  FIFO is non-empty.
- `out_ready`  in  1  consumer accepts; the head is popped when `out_valid & out_ready`.
- `sat_clr`  in  1  synchronous clear of `sat_cnt`.
- `sat_cnt`  out  16  count of saturated outputs; saturates at 0xFFFF.

## Operation
- **Stage S1** (registered on accept): `sum1 = sext(acc_data) + sext(bias)`, computed at ACC_WIDTH+2 bits so it cannot overflow.
- **Stage S2**:
  - `shift = 0`: `r = sum1`.
  - `shift > 0`: `r = (sum1 + (1 << (shift-1))) >>> shift`. This is round-half-up (toward +inf) with an arithmetic shift.
  - ReLU: if `relu_en` and `r < 0`, then `r = 0`.
- **Stage S3**: saturate `r` to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1], i.e. [-32768, 32767] by default, then write the result to the FIFO.
  - `sat_cnt` increments by 1 for each written value whose pre-saturation `r` was out of range.
  - A ReLU-clamped 0 is not counted.
- Each stage carries a valid bit. S1..S3 always advance; there is no stall path.
- **Credit rule**:
  - `inflight` = number of set valid bits in S1..S3.
  - `acc_ready = !rst_q && (fifo_count + inflight < FIFO_DEPTH)`, where `rst_q` is a registered copy of `rst`.
  - `acc_ready` is derived only from registers; it has no combinational path from `out_ready` or `acc_valid`.
  - A pop this cycle raises `acc_ready` one cycle later.
- **FIFO**: strictly in order.
  - A simultaneous push and pop is allowed at any occupancy, including full (the pop frees the slot) and empty. When both occur on an empty FIFO, the pushed value becomes the head next cycle and is not popped.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - The credit rule guarantees no push to a full FIFO. Pushing to a full FIFO is an assertion failure in the bench.
- **`sat_cnt`**: `sat_clr` has priority over an increment in the same cycle, and the result is 0.
- **Reset** (`rst` = 1 at a rising edge):
  - All valid bits, FIFO pointers, `fifo_count` and `sat_cnt` go to 0.
  - Outputs: `out_valid` = 0, `out_data` = 0, `acc_ready` = 0 for the cycle after reset.
  - In-flight and buffered data are discarded, including during reset mid-operation.
  - `acc_ready` returns to 1 in the second cycle after `rst` deasserts.

## Timing
- Latency:
  - A sum accepted at edge t appears in S1 after t, S2 after t+1, and is written to the FIFO at edge t+2.
  - It is visible on `out_data`/`out_valid` in cycle t+3 when the FIFO was empty: 3 cycles accept-to-output.
- Throughput: one sum per cycle while `out_ready` = 1 continuously, given FIFO_DEPTH ≥ 4.
- With `out_ready` held at 0, at most FIFO_DEPTH sums are accepted before `acc_ready` drops.
- `out_data` is driven from the FIFO head register, not recomputed combinationally.

## Test plan
- **Pass-through**: shift=0, bias=0, relu_en=0, acc_data=100 accepted at edge t -> `out_valid`=1, `out_data`=100 in cycle t+3; `sat_cnt`=0.
- **Rounding**: shift=4, bias=0, acc_data sequence 24, 23, -24, -25 -> outputs 2, 1, -1, -2 in order.
- **Bias and saturation**:
  - acc_data=2^20, bias=5, shift=0 -> 32767, `sat_cnt`=1.
  - acc_data=-2^20 -> -32768, `sat_cnt`=2.
  - `sat_clr` asserted together with a third saturating result -> `sat_cnt`=0.
- **ReLU**: relu_en=1, shift=0, acc_data=-5 -> 0 with `sat_cnt` unchanged; acc_data=7 -> 7.
- **Backpressure and wrap**:
  - Hold out_ready=0 with acc_valid=1 continuously (values 1..10) -> exactly 4 accepted, then `acc_ready`=0.
  - Then set out_ready=1 -> outputs 1..10 in order with no loss or duplication.
  - FIFO pointers wrap at least twice; the bench checks that `acc_ready` never permits overflow.
- **Reset mid-operation**: 2 sums in flight and 2 buffered, `rst` high for 1 cycle -> `out_valid` stays 0 afterwards, `sat_cnt`=0, and `acc_ready`=1 from the second cycle after reset.
